// File: rtl/kf8259_host_pkg.sv
// Shared types for the KF8259 host-side bus initiator: FSM states, timer width, latched command.
package kf8259_host_pkg;

    localparam int unsigned TIMER_WIDTH = 4;
    localparam int unsigned DATA_WIDTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_INTA1,
        ST_INTA_GAP,
        ST_INTA2,
        ST_VECTOR
    } state_e;

    typedef struct packed {
        logic                  write;
        logic                  address;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/kf8259_strobe_timer.sv
// Load/decrement phase timer; done_o is high while the count sits at zero (no wrap-around).
module kf8259_strobe_timer
    import kf8259_host_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   load_i,
    input  logic [TIMER_WIDTH-1:0] load_value_i,
    output logic                   done_o
);

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;
    logic                   done_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            done_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            done_q  <= (count_d == '0);
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/kf8259_host_interface.sv
// CPU-side initiator for a KF8259 PIC: timed CS#/RD#/WR# bus cycles and the two-pulse INTA
// sequence with vector capture, handed to the host over valid/ready.
module kf8259_host_interface
    import kf8259_host_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  int_enable,
    input  logic                  interrupt_to_cpu,
    output logic                  vector_valid,
    output logic [DATA_WIDTH-1:0] vector,
    input  logic                  vector_ready,
    output logic                  chip_select_n,
    output logic                  read_enable_n,
    output logic                  write_enable_n,
    output logic                  address,
    output logic [DATA_WIDTH-1:0] data_bus_out,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic                  interrupt_acknowledge_n
);

    localparam logic [TIMER_WIDTH-1:0] STROBE_LOAD = TIMER_WIDTH'(STROBE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] GAP_LOAD    = TIMER_WIDTH'(GAP_CYCLES - 1);

    state_e                  state_q;
    cmd_t                    cmd_q;
    logic                    cs_n_q;
    logic                    rd_n_q;
    logic                    wr_n_q;
    logic                    inta_n_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    vector_valid_q;
    logic [DATA_WIDTH-1:0]   vector_q;

    logic                    irq_c;
    logic                    timer_load_c;
    logic [TIMER_WIDTH-1:0]  timer_value_c;
    logic                    timer_done;

    assign irq_c     = interrupt_to_cpu & int_enable;
    assign cmd_ready = (state_q == ST_IDLE) && !irq_c;

    // Timer reloads on the same edge that enters each timed phase.
    always_comb begin
        timer_load_c  = 1'b0;
        timer_value_c = STROBE_LOAD;
        case (state_q)
            ST_IDLE:     timer_load_c = irq_c;
            ST_SETUP:    timer_load_c = 1'b1;
            ST_INTA1: begin
                timer_load_c  = timer_done;
                timer_value_c = GAP_LOAD;
            end
            ST_INTA_GAP: timer_load_c = timer_done;
            default:     timer_load_c = 1'b0;
        endcase
    end

    kf8259_strobe_timer u_timer (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_i       (timer_load_c),
        .load_value_i (timer_value_c),
        .done_o       (timer_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            cs_n_q         <= 1'b1;
            rd_n_q         <= 1'b1;
            wr_n_q         <= 1'b1;
            inta_n_q       <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            vector_valid_q <= 1'b0;
            vector_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A pending interrupt wins over a command presented in the same cycle.
                    if (irq_c) begin
                        inta_n_q <= 1'b0;
                        state_q  <= ST_INTA1;
                    end else if (cmd_valid) begin
                        cmd_q.write   <= cmd_write;
                        cmd_q.address <= cmd_address;
                        cmd_q.wdata   <= cmd_write ? cmd_wdata : '0;
                        cs_n_q        <= 1'b0;
                        state_q       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    rd_n_q  <= cmd_q.write;
                    wr_n_q  <= !cmd_q.write;
                    state_q <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (timer_done) begin
                        rd_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        state_q <= ST_HOLD;
                        if (!cmd_q.write) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= data_bus_in;
                        end
                    end
                end
                ST_HOLD: begin
                    cs_n_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_INTA1: begin
                    if (timer_done) begin
                        inta_n_q <= 1'b1;
                        state_q  <= ST_INTA_GAP;
                    end
                end
                ST_INTA_GAP: begin
                    if (timer_done) begin
                        inta_n_q <= 1'b0;
                        state_q  <= ST_INTA2;
                    end
                end
                ST_INTA2: begin
                    if (timer_done) begin
                        inta_n_q       <= 1'b1;
                        vector_q       <= data_bus_in;
                        vector_valid_q <= 1'b1;
                        state_q        <= ST_VECTOR;
                    end
                end
                ST_VECTOR: begin
                    if (vector_ready) begin
                        vector_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign chip_select_n           = cs_n_q;
    assign read_enable_n           = rd_n_q;
    assign write_enable_n          = wr_n_q;
    assign interrupt_acknowledge_n = inta_n_q;
    assign address                 = cmd_q.address;
    assign data_bus_out            = cmd_q.wdata;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_rdata               = rsp_rdata_q;
    assign vector_valid            = vector_valid_q;
    assign vector                  = vector_q;

endmodule

// File: tb/tb_kf8259_host_interface.sv
// Directed bench for kf8259_host_interface: cycle-accurate strobe checks plus read/vector scoreboards.
module tb_kf8259_host_interface;

    localparam int unsigned STROBE = 2;
    localparam int unsigned GAP    = 1;

    logic       clock;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_address;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       int_enable;
    logic       interrupt_to_cpu;
    logic       vector_valid;
    logic [7:0] vector;
    logic       vector_ready;
    logic       chip_select_n;
    logic       read_enable_n;
    logic       write_enable_n;
    logic       address;
    logic [7:0] data_bus_out;
    logic [7:0] data_bus_in;
    logic       interrupt_acknowledge_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] rsp_q[$];
    logic [7:0] vec_q[$];

    kf8259_host_interface #(
        .STROBE_CYCLES (STROBE),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_write               (cmd_write),
        .cmd_address             (cmd_address),
        .cmd_wdata               (cmd_wdata),
        .rsp_valid               (rsp_valid),
        .rsp_rdata               (rsp_rdata),
        .int_enable              (int_enable),
        .interrupt_to_cpu        (interrupt_to_cpu),
        .vector_valid            (vector_valid),
        .vector                  (vector),
        .vector_ready            (vector_ready),
        .chip_select_n           (chip_select_n),
        .read_enable_n           (read_enable_n),
        .write_enable_n          (write_enable_n),
        .address                 (address),
        .data_bus_out            (data_bus_out),
        .data_bus_in             (data_bus_in),
        .interrupt_acknowledge_n (interrupt_acknowledge_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void checkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endfunction

    function automatic void check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Output monitor: every response/vector handshake must match the next queued expectation.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (rsp_valid === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL rsp_unexpected observed=%02h expected=none", rsp_rdata);
                end else begin
                    check8("rsp_scoreboard", rsp_rdata, rsp_q.pop_front());
                end
            end
            if (vector_valid === 1'b1 && vector_ready === 1'b1) begin
                if (vec_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL vec_unexpected observed=%02h expected=none", vector);
                end else begin
                    check8("vec_scoreboard", vector, vec_q.pop_front());
                end
            end
        end
    end

    // One complete host bus command, checked cycle by cycle from acceptance to release of CS#.
    task automatic bus_cycle(input logic wr, input logic a0, input logic [7:0] wd, input logic [7:0] rd);
        cmd_write   = wr;
        cmd_address = a0;
        cmd_wdata   = wd;
        data_bus_in = rd;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 30 && cmd_ready !== 1'b1; i++) tick();
        checkb("accept_ready", cmd_ready, 1'b1);
        if (!wr) rsp_q.push_back(rd);
        tick();
        cmd_valid = 1'b0;
        checkb("setup_cs_n", chip_select_n, 1'b0);
        checkb("setup_addr", address, a0);
        checkb("setup_rd_n", read_enable_n, 1'b1);
        checkb("setup_wr_n", write_enable_n, 1'b1);
        checkb("setup_inta_n", interrupt_acknowledge_n, 1'b1);
        if (wr) check8("setup_dout", data_bus_out, wd);
        tick();
        for (int s = 0; s < int'(STROBE); s++) begin
            checkb("strobe_rd_n", read_enable_n, wr);
            checkb("strobe_wr_n", write_enable_n, !wr);
            checkb("strobe_cs_n", chip_select_n, 1'b0);
            checkb("strobe_inta_n", interrupt_acknowledge_n, 1'b1);
            tick();
        end
        checkb("hold_rd_n", read_enable_n, 1'b1);
        checkb("hold_wr_n", write_enable_n, 1'b1);
        checkb("hold_cs_n", chip_select_n, 1'b0);
        checkb("hold_addr", address, a0);
        checkb("hold_rsp_valid", rsp_valid, !wr);
        if (!wr) check8("hold_rsp_rdata", rsp_rdata, rd);
        if (wr) check8("hold_dout", data_bus_out, wd);
        tick();
        checkb("end_cs_n", chip_select_n, 1'b1);
        checkb("end_rsp_valid", rsp_valid, 1'b0);
    endtask

    // INTA sequence starting from IDLE with an enabled interrupt pending; drop_phase 0 drops INT in
    // INTA1, 1 drops it in the gap. The vector is held for 'hold' cycles before the host takes it.
    task automatic inta_seq(input logic [7:0] vec, input int hold, input int drop_phase);
        checkb("inta_cmd_ready", cmd_ready, 1'b0);
        vec_q.push_back(vec);
        data_bus_in = vec;
        tick();
        for (int s = 0; s < int'(STROBE); s++) begin
            checkb("inta1_n", interrupt_acknowledge_n, 1'b0);
            checkb("inta1_cs_n", chip_select_n, 1'b1);
            checkb("inta1_vvalid", vector_valid, 1'b0);
            if (s == 0 && drop_phase == 0) interrupt_to_cpu = 1'b0;
            tick();
        end
        for (int g = 0; g < int'(GAP); g++) begin
            checkb("gap_inta_n", interrupt_acknowledge_n, 1'b1);
            if (g == 0 && drop_phase == 1) interrupt_to_cpu = 1'b0;
            tick();
        end
        for (int s = 0; s < int'(STROBE); s++) begin
            checkb("inta2_n", interrupt_acknowledge_n, 1'b0);
            checkb("inta2_vvalid", vector_valid, 1'b0);
            tick();
        end
        for (int h = 0; h < hold; h++) begin
            checkb("vec_valid_hold", vector_valid, 1'b1);
            check8("vec_value_hold", vector, vec);
            checkb("vec_inta_n", interrupt_acknowledge_n, 1'b1);
            if (h == hold - 1) vector_ready = 1'b1;
            tick();
        end
        vector_ready = 1'b0;
        checkb("vec_cleared", vector_valid, 1'b0);
        checkb("vec_idle_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b1;
        cmd_valid        = 1'b0;
        cmd_write        = 1'b0;
        cmd_address      = 1'b0;
        cmd_wdata        = 8'h00;
        int_enable       = 1'b0;
        interrupt_to_cpu = 1'b0;
        vector_ready     = 1'b0;
        data_bus_in      = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        checkb("rst_cs_n", chip_select_n, 1'b1);
        checkb("rst_rd_n", read_enable_n, 1'b1);
        checkb("rst_wr_n", write_enable_n, 1'b1);
        checkb("rst_inta_n", interrupt_acknowledge_n, 1'b1);
        checkb("rst_addr", address, 1'b0);
        check8("rst_dout", data_bus_out, 8'h00);
        check8("rst_rdata", rsp_rdata, 8'h00);
        check8("rst_vector", vector, 8'h00);
        checkb("rst_rsp_valid", rsp_valid, 1'b0);
        checkb("rst_vec_valid", vector_valid, 1'b0);
        checkb("rst_cmd_ready", cmd_ready, 1'b1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // ICW1 write, then an IMR read.
        bus_cycle(1'b1, 1'b0, 8'h13, 8'h00);
        checkb("post_write_ready", cmd_ready, 1'b1);
        bus_cycle(1'b0, 1'b1, 8'h00, 8'hA5);

        // INTA with the vector held three cycles before the host consumes it.
        int_enable       = 1'b1;
        interrupt_to_cpu = 1'b1;
        #1;
        inta_seq(8'h4B, 3, 0);

        // Command and interrupt arrive together: INTA first, then the command.
        cmd_write        = 1'b1;
        cmd_address      = 1'b1;
        cmd_wdata        = 8'hFE;
        cmd_valid        = 1'b1;
        interrupt_to_cpu = 1'b1;
        #1;
        checkb("collide_ready", cmd_ready, 1'b0);
        inta_seq(8'h50, 1, 0);
        bus_cycle(1'b1, 1'b1, 8'hFE, 8'h00);

        // Interrupts masked at the CPU: INTA# stays high and commands run.
        int_enable       = 1'b0;
        interrupt_to_cpu = 1'b1;
        #1;
        checkb("masked_ready", cmd_ready, 1'b1);
        bus_cycle(1'b0, 1'b0, 8'h00, 8'h81);
        checkb("masked_inta_n", interrupt_acknowledge_n, 1'b1);

        // Enable with INT pending, then drop INT during the gap: spurious vector still delivered.
        int_enable = 1'b1;
        #1;
        inta_seq(8'h47, 1, 1);

        // Reset asserted in the middle of INTA2.
        interrupt_to_cpu = 1'b1;
        data_bus_in      = 8'h99;
        #1;
        tick();
        interrupt_to_cpu = 1'b0;
        for (int i = 0; i < int'(STROBE + GAP); i++) tick();
        checkb("pre_rst_inta2", interrupt_acknowledge_n, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checkb("midrst_inta_n", interrupt_acknowledge_n, 1'b1);
        checkb("midrst_vvalid", vector_valid, 1'b0);
        checkb("midrst_cs_n", chip_select_n, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checkb("postrst_ready", cmd_ready, 1'b1);
        checkb("postrst_inta_n", interrupt_acknowledge_n, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        checkb("postrst_no_vec", vector_valid, 1'b0);
        checkb("postrst_no_rsp", rsp_valid, 1'b0);

        checkb("rsp_queue_drained", rsp_q.size() == 0, 1'b1);
        checkb("vec_queue_drained", vec_q.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kf8259_host_interface.md
Name: kf8259_host_interface

Overview:
CPU-side bus initiator that drives a KF8259 PIC. It turns a simple valid/ready command port into correctly timed chip-select, read and write strobes for ICW/OCW writes and IRR/ISR/IMR reads. When the PIC raises interrupt_to_cpu and interrupts are enabled, it runs the two-pulse 8086-mode INTA sequence, captures the vector byte, and hands the vector to the host core over a valid/ready handshake. The block sits between a soft CPU core (or test host) and the PIC's bus and INTA pins.

Parameters:
STROBE_CYCLES, 2, clocks each RD/WR/INTA strobe is held low (legal range 1..15).
GAP_CYCLES, 1, clocks interrupt_acknowledge_n is held high between INTA pulse 1 and pulse 2 (legal range 1..15).

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  host bus command present
cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high
cmd_write  input  1  1 = write, 0 = read
cmd_address  input  1  PIC A0
cmd_wdata  input  8  write data
rsp_valid  output  1  one-cycle pulse; rsp_rdata is valid in that cycle
rsp_rdata  output  8  read result
int_enable  input  1  CPU interrupt flag
interrupt_to_cpu  input  1  PIC INT
vector_valid  output  1  captured vector available
vector  output  8  interrupt vector byte
vector_ready  input  1  host consumes the vector
chip_select_n  output  1  PIC CS#
read_enable_n  output  1  PIC RD#
write_enable_n  output  1  PIC WR#
address  output  1  PIC A0
data_bus_out  output  8  data driven to the PIC
data_bus_in  input  8  data returned by the PIC
interrupt_acknowledge_n  output  1  PIC INTA#

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on reset_n.
- Registered outputs: all bus outputs, vector, vector_valid, rsp_valid and rsp_rdata are registered.
- Reset values:
  - chip_select_n, read_enable_n, write_enable_n and interrupt_acknowledge_n are 1.
  - address, data_bus_out, rsp_rdata and vector are 0.
  - rsp_valid and vector_valid are 0.
  - State is IDLE.
- Reset mid-operation: strobes return high immediately (asynchronously), no response or vector is produced, and the block restarts in IDLE.
- cmd_ready is combinational: high only when state is IDLE and (interrupt_to_cpu and int_enable) is 0. Pending INTA has priority over a simultaneous command.
- FSM states: IDLE, SETUP, STROBE, HOLD, INTA1, INTA_GAP, INTA2, VECTOR.
- IDLE:
  - If interrupt_to_cpu and int_enable are both 1, go to INTA1.
  - Otherwise, on cmd_valid and cmd_ready, latch write/address/wdata and go to SETUP.
- SETUP (1 cycle): chip_select_n = 0, address and data_bus_out (writes only) driven, strobes high.
- STROBE (STROBE_CYCLES cycles): read_enable_n or write_enable_n = 0. A read captures data_bus_in on the clock edge that ends the last strobe cycle.
- HOLD (1 cycle): strobe high; chip_select_n, address and data are still driven. For reads, rsp_valid = 1 with the captured byte. Then go to IDLE with chip_select_n = 1.
- Write timing: no response for writes. A command occupies the bus for exactly STROBE_CYCLES+2 cycles after acceptance.
- INTA1 (STROBE_CYCLES cycles): interrupt_acknowledge_n = 0, chip_select_n = 1. Then INTA_GAP (GAP_CYCLES cycles, INTA# high), then INTA2 (STROBE_CYCLES cycles, INTA# low).
- Vector capture: the vector is taken from data_bus_in on the edge ending the last INTA2 cycle. Then go to VECTOR.
- INTA commitment: once INTA1 has started, the sequence always completes, even if interrupt_to_cpu or int_enable drops (the PIC supplies its spurious IR7 vector).
- VECTOR: vector_valid = 1 and vector is held stable until vector_ready = 1 in the same cycle. vector_valid then clears and the state returns to IDLE; a new INTA can start the following cycle.
- Timing counter: one shared down-counter of width 4. It loads STROBE_CYCLES-1 or GAP_CYCLES-1 on state entry and the state advances when the counter reaches 0. There is no wrap-around.

Decomposition:
- Package kf8259_host_pkg:
  - state enum (IDLE..VECTOR);
  - TIMER_WIDTH = 4;
  - a command struct {write, address, wdata}.
- One natural sub-module, kf8259_strobe_timer: a load/decrement counter with a done flag, shared by the bus and INTA phases.

Test Plan:
1. Write ICW1 = 0x13 at A0 = 0 (STROBE_CYCLES = 2): accepted at T0 → T1 CS#=0, addr 0, data 0x13 → T2..T3 WR#=0 → T4 WR#=1, CS#=0 → T5 CS#=1, cmd_ready=1; rsp_valid never asserted.
2. Read IMR at A0 = 1 with data_bus_in = 0xA5 → RD# low at T2..T3, rsp_valid=1 and rsp_rdata=0xA5 at T4 only.
3. interrupt_to_cpu=1, int_enable=1, data_bus_in=0x4B during INTA2 → INTA# low 2 cycles, high 1 cycle, low 2 cycles → vector_valid=1, vector=0x4B; held 3 cycles while vector_ready=0, cleared on the cycle after vector_ready=1.
4. cmd_valid=1 in the same cycle interrupt_to_cpu rises (int_enable=1) → cmd_ready=0, INTA sequence runs first; the command is accepted only after the vector handshake, then completes normally.
5. int_enable=0 with interrupt_to_cpu=1 → INTA# stays 1, commands proceed. Dropping interrupt_to_cpu during INTA_GAP → sequence still completes and the vector (0x47) is delivered.
6. reset_n pulsed low during INTA2 → INTA# goes 1 asynchronously, vector_valid=0; after release the block is in IDLE and cmd_ready=1 with no interrupt pending.
